// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA constants, field positions and fetch-path types
// Purpose: opcode values, instruction field positions, bus widths, fetch buffer
//          entry type and the fetch FSM state type used by the fetch slice.
// Ports:   none (package).
package isa_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  // Opcodes
  localparam logic [5:0] OPC_ALU   = 6'b000000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] JUMP_OPC  = 6'b010100;
  localparam logic [5:0] OPC_LOAD  = 6'b100011;
  localparam logic [5:0] OPC_STORE = 6'b101011;

  // Instruction field positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS_MSB  = 20;
  localparam int RS_LSB  = 16;
  localparam int RT_MSB  = 15;
  localparam int RT_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  function automatic logic [5:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [15:0] get_imm(input logic [INSTR_W-1:0] instr);
    return instr[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - memory, redirect and decode-side signals of the fetch unit
// Purpose: bundles every non-clock signal of instr_fetch_unit.
// Ports:   master = fetch unit (drives imem_addr, out_*, halted, fetch_count);
//          slave  = surrounding pipeline/memory (drives imem_instr, redirect_*, out_ready).
interface instr_fetch_unit_if;
  import isa_pkg::*;

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_target;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, halted, fetch_count,
    input  imem_instr, redirect_valid, redirect_target, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, halted, fetch_count,
    output imem_instr, redirect_valid, redirect_target, out_ready
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - 2-entry FIFO of {instr, pc} between fetch and decode
// Purpose: holds fetched instructions so fetch can run 1/cycle under backpressure.
// Ports:   clk, rst (async high); i_push/i_data enqueue; i_pop dequeue head;
//          i_flush empties (wins over push/pop); o_head head entry; o_count 0..2.
module fetch_skid_buf
  import isa_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);

  fetch_entry_t r_data [2];
  logic [1:0]   r_count;
  logic         w_pop;

  // Popping an empty buffer is ignored.
  assign w_pop   = i_pop && (r_count != 2'd0);
  assign o_head  = r_data[0];
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_count   <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b11: begin
          // Count unchanged; new entry lands behind whatever remains.
          if (r_count == 2'd2) begin
            r_data[0] <= r_data[1];
            r_data[1] <= i_data;
          end else begin
            r_data[0] <= i_data;
          end
        end
        2'b10: begin
          if (r_count == 2'd0) r_data[0] <= i_data;
          else                 r_data[1] <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_data[0] <= r_data[1];
          r_count   <= r_count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, redirect, self-jump halt and fetch counter feeding decode
// Purpose: drives the combinational instruction memory from the PC and queues
//          {instr, pc} into a 2-entry skid buffer presented over valid/ready.
// Ports:   clk, rst (async high); bus (master modport): imem_addr/imem_instr,
//          redirect_valid/redirect_target, out_valid/out_ready/out_instr/out_pc,
//          halted, fetch_count.
module instr_fetch_unit
  import isa_pkg::*;
#(
  parameter logic [ADDR_W-1:0] P_RESET_PC = RESET_PC,
  parameter logic [5:0]        P_JUMP_OPC = JUMP_OPC
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_unit_if.master  bus
);

  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_fetch_count;
  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;

  logic              w_pop;
  logic              w_fetch_en;
  logic              w_self_jump;
  logic [1:0]        w_count;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_data;

  assign w_pop = bus.out_valid && bus.out_ready;

  // A pop frees a slot in the same cycle, so a full buffer still fetches.
  assign w_fetch_en = (r_state == ST_RUN) && !bus.redirect_valid &&
                      ((w_count != 2'd2) || w_pop);

  assign w_self_jump = (get_opcode(bus.imem_instr) == P_JUMP_OPC) &&
                       (get_imm(bus.imem_instr) == r_pc);

  assign w_push_data = '{instr: bus.imem_instr, pc: r_pc};

  fetch_skid_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fetch_en),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Redirect has priority: it clears halt and suppresses the self-jump check.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.redirect_valid)               w_state_nxt = ST_RUN;
    else if (w_fetch_en && w_self_jump)   w_state_nxt = ST_HALT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= P_RESET_PC;
      r_fetch_count <= '0;
    end else if (bus.redirect_valid) begin
      r_pc <= bus.redirect_target;
    end else if (w_fetch_en) begin
      r_pc          <= r_pc + 1'b1;
      r_fetch_count <= r_fetch_count + 1'b1;
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.out_valid   = (w_count != 2'd0);
  assign bus.out_instr   = w_head.instr;
  assign bus.out_pc      = w_head.pc;
  assign bus.halted      = (r_state == ST_HALT);
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import isa_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory: address-tagged words; address 20 holds a jump to itself.
  assign bus.imem_instr = (bus.imem_addr == 16'd20) ? 32'h5000_0014
                                                    : {16'hC0DE, bus.imem_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.out_ready       = 1'b1;
    tick();
    check("rst_valid",  {31'b0, bus.out_valid}, 32'd0);
    check("rst_halted", {31'b0, bus.halted},    32'd0);
    check("rst_count",  bus.fetch_count,        32'd0);
    check("rst_addr",   {16'b0, bus.imem_addr}, 32'd0);
    check("rst_instr",  bus.out_instr,          32'd0);
    check("rst_pc",     {16'b0, bus.out_pc},    32'd0);
    rst = 1'b0;

    // Streaming with out_ready high
    tick();
    check("s_valid1", {31'b0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      check($sformatf("s_pc%0d", i), {16'b0, bus.out_pc}, i);
      check($sformatf("s_instr%0d", i), bus.out_instr, {16'hC0DE, 16'(i)});
    end
    check("s_count", bus.fetch_count, 32'd4);
    check("s_addr",  {16'b0, bus.imem_addr}, 32'd4);

    // Backpressure: buffer fills, PC holds at 3
    do_reset();
    tick();  // head 0
    tick();  // head 1, pc 2
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("bp_addr",  {16'b0, bus.imem_addr}, 32'd3);
    check("bp_pc",    {16'b0, bus.out_pc},    32'd1);
    check("bp_valid", {31'b0, bus.out_valid}, 32'd1);
    check("bp_count", bus.fetch_count,        32'd3);
    bus.out_ready = 1'b1;
    tick();
    check("bp_drain2", {16'b0, bus.out_pc}, 32'd2);
    tick();
    check("bp_drain3", {16'b0, bus.out_pc}, 32'd3);
    check("bp_count2", bus.fetch_count,     32'd5);

    // Redirect with a full buffer
    bus.out_ready       = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h0040;
    tick();
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    check("rd_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rd_addr",  {16'b0, bus.imem_addr}, 32'h40);
    check("rd_count", bus.fetch_count,        32'd5);
    tick();
    check("rd_pc",     {16'b0, bus.out_pc},    32'h40);
    check("rd_valid2", {31'b0, bus.out_valid}, 32'd1);
    check("rd_count2", bus.fetch_count,        32'd6);

    // Self-jump at 20 halts fetching
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'd18;
    tick();
    bus.redirect_valid = 1'b0;
    tick();  // 18
    tick();  // 19
    tick();  // 20 enqueued
    check("h_halted", {31'b0, bus.halted},    32'd1);
    check("h_addr",   {16'b0, bus.imem_addr}, 32'd21);
    check("h_pc",     {16'b0, bus.out_pc},    32'd20);
    check("h_instr",  bus.out_instr,          32'h5000_0014);
    check("h_count",  bus.fetch_count,        32'd9);
    tick();
    check("h_drain",  {31'b0, bus.out_valid}, 32'd0);
    check("h_addr2",  {16'b0, bus.imem_addr}, 32'd21);
    check("h_count2", bus.fetch_count,        32'd9);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'd0;
    tick();
    bus.redirect_valid = 1'b0;
    check("h_clear", {31'b0, bus.halted}, 32'd0);
    tick();
    check("h_resume", {16'b0, bus.out_pc}, 32'd0);
    check("h_count3", bus.fetch_count,     32'd10);

    // Redirect while the self-jump is on the memory bus: redirect wins
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'd20;
    tick();
    bus.redirect_target = 16'h0040;
    tick();
    bus.redirect_valid = 1'b0;
    check("rw_halted", {31'b0, bus.halted},    32'd0);
    check("rw_addr",   {16'b0, bus.imem_addr}, 32'h40);
    check("rw_count",  bus.fetch_count,        32'd10);

    // PC wrap
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'hFFFF;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check("w_pc0", {16'b0, bus.out_pc}, 32'hFFFF);
    tick();
    check("w_pc1", {16'b0, bus.out_pc}, 32'h0000);
    tick();
    check("w_pc2", {16'b0, bus.out_pc}, 32'h0001);
    check("w_count", bus.fetch_count,   32'd13);

    // Asynchronous reset mid-cycle with two entries buffered
    bus.out_ready = 1'b0;
    tick();
    check("ar_addr_pre", {16'b0, bus.imem_addr}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid",  {31'b0, bus.out_valid}, 32'd0);
    check("ar_halted", {31'b0, bus.halted},    32'd0);
    check("ar_count",  bus.fetch_count,        32'd0);
    check("ar_addr",   {16'b0, bus.imem_addr}, 32'd0);
    tick();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
